// File: rtl/cf_weighted_sum.sv
// cf_weighted_sum: delay-and-sum beamformer back end. Eight offset-binary
// channel samples are converted to two's complement, summed through a
// three-level registered adder tree, delayed to line up with the coherence
// coefficient, weighted by coff/256 and emitted with framing and an index.
//
// Stream semantics: valid-only, no backpressure. A beat is transferred on
// every rising edge where din_valid is high; the output side presents one
// beat per cycle in which dout_valid is high and never stalls. The data path
// shifts every cycle regardless of valid.
module cf_weighted_sum #(
  parameter int ALIGN_DLY = 24,
  parameter int IDX_W     = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  input  logic                    line_start,
  input  logic [11:0]             Data_A,
  input  logic [11:0]             Data_B,
  input  logic [11:0]             Data_C,
  input  logic [11:0]             Data_D,
  input  logic [11:0]             Data_E,
  input  logic [11:0]             Data_F,
  input  logic [11:0]             Data_G,
  input  logic [11:0]             Data_H,
  input  logic [7:0]              coff,
  input  logic                    cf_en,
  output logic signed [14:0]      dout,
  output logic                    dout_valid,
  output logic                    dout_sol,
  output logic [IDX_W-1:0]        dout_idx
);

  // Side-pipeline depth: conversion, three adder levels, the delay line and
  // the multiplier stage. The output register follows it.
  localparam int SIDE = ALIGN_DLY + 5;

  logic [11:0]        raw      [8];
  logic signed [11:0] conv_d   [8];
  logic signed [11:0] conv_q   [8];
  logic signed [14:0] lvl1_d   [4];
  logic signed [14:0] lvl1_q   [4];
  logic signed [14:0] lvl2_d   [2];
  logic signed [14:0] lvl2_q   [2];
  logic signed [14:0] sum_d;
  logic signed [14:0] sum_q;
  logic signed [14:0] dly_q    [ALIGN_DLY];
  logic signed [9:0]  coef_s;
  logic signed [23:0] prod_d;
  logic signed [23:0] prod_q;
  logic [SIDE-1:0]    vld_q;
  logic [SIDE-1:0]    sol_q;
  logic signed [14:0] dout_d;
  logic signed [14:0] dout_q;
  logic               dout_valid_q;
  logic               dout_sol_q;
  logic [IDX_W-1:0]   idx_d;
  logic [IDX_W-1:0]   idx_q;

  // Offset binary to two's complement: invert the MSB of each channel.
  always_comb begin
    raw[0] = Data_A;
    raw[1] = Data_B;
    raw[2] = Data_C;
    raw[3] = Data_D;
    raw[4] = Data_E;
    raw[5] = Data_F;
    raw[6] = Data_G;
    raw[7] = Data_H;
    for (int i = 0; i < 8; i++) begin
      conv_d[i] = signed'({~raw[i][11], raw[i][10:0]});
    end
  end

  // Adder tree 8->4->2->1 at 15 bits; the full range -16384..16376 fits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1_d[i] = {{3{conv_q[2*i][11]}}, conv_q[2*i]} +
                  {{3{conv_q[2*i+1][11]}}, conv_q[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      lvl2_d[i] = lvl1_q[2*i] + lvl1_q[2*i+1];
    end
    sum_d = lvl2_q[0] + lvl2_q[1];
  end

  // Weighting: coefficient 256 in bypass, otherwise coff as an unsigned
  // 0..255 value; the product fits 24 bits signed since |sum*256| <= 2^22.
  always_comb begin
    coef_s = cf_en ? signed'({2'b00, coff}) : 10'sd256;
    prod_d = 24'(dly_q[ALIGN_DLY-1]) * 24'(coef_s);
  end

  // Output value, gated to zero on invalid cycles, and the line index which
  // restarts on sol, saturates at all-ones and holds across gaps.
  always_comb begin
    dout_d = vld_q[SIDE-1] ? 15'(prod_q >>> 8) : 15'sd0;
    idx_d  = idx_q;
    if (vld_q[SIDE-1]) begin
      if (sol_q[SIDE-1]) begin
        idx_d = '0;
      end else if (!(&idx_q)) begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Data path, delay line and side pipeline; everything clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) conv_q[i] <= '0;
      for (int i = 0; i < 4; i++) lvl1_q[i] <= '0;
      for (int i = 0; i < 2; i++) lvl2_q[i] <= '0;
      sum_q <= '0;
      for (int i = 0; i < ALIGN_DLY; i++) dly_q[i] <= '0;
      prod_q       <= '0;
      vld_q        <= '0;
      sol_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sol_q   <= 1'b0;
      idx_q        <= '0;
    end else begin
      for (int i = 0; i < 8; i++) conv_q[i] <= conv_d[i];
      for (int i = 0; i < 4; i++) lvl1_q[i] <= lvl1_d[i];
      for (int i = 0; i < 2; i++) lvl2_q[i] <= lvl2_d[i];
      sum_q    <= sum_d;
      dly_q[0] <= sum_q;
      for (int i = 1; i < ALIGN_DLY; i++) dly_q[i] <= dly_q[i-1];
      prod_q       <= prod_d;
      vld_q        <= {vld_q[SIDE-2:0], din_valid};
      sol_q        <= {sol_q[SIDE-2:0], din_valid & line_start};
      dout_q       <= dout_d;
      dout_valid_q <= vld_q[SIDE-1];
      dout_sol_q   <= vld_q[SIDE-1] & sol_q[SIDE-1];
      idx_q        <= idx_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_sol   = dout_sol_q;
  assign dout_idx   = idx_q;

endmodule

// File: tb/tb_cf_weighted_sum.sv
// Bench for cf_weighted_sum: directed beats with hand-computed results,
// expected responses queued at issue and checked by a negedge monitor.
module tb_cf_weighted_sum;

  localparam int ALIGN_DLY = 24;
  localparam int IDX_W     = 12;
  localparam int LAT       = ALIGN_DLY + 5;

  // Channel patterns, packed {A,B,C,D,E,F,G,H}
  localparam logic [95:0] ALL_FFF = {8{12'hFFF}};
  localparam logic [95:0] ALL_000 = {8{12'h000}};
  localparam logic [95:0] HALF_C  = {{4{12'hC00}}, {4{12'h800}}};
  localparam logic [95:0] A_7FF   = {12'h7FF, {7{12'h800}}};
  localparam logic [95:0] A_801   = {12'h801, {7{12'h800}}};
  localparam logic [95:0] A_FFF   = {12'hFFF, {7{12'h800}}};

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    din_valid = 1'b0;
  logic                    line_start = 1'b0;
  logic [95:0]             ch = {8{12'h800}};
  logic [7:0]              coff = 8'd0;
  logic                    cf_en = 1'b1;
  logic signed [14:0]      dout;
  logic                    dout_valid;
  logic                    dout_sol;
  logic [IDX_W-1:0]        dout_idx;

  int unsigned             cyc = 0;
  int                      tests = 0;
  int                      fails = 0;
  logic [59:0]             exp_q[$];
  logic [IDX_W-1:0]        model_idx = '0;
  logic [IDX_W-1:0]        held_idx = '0;

  cf_weighted_sum #(.ALIGN_DLY(ALIGN_DLY), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .line_start (line_start),
    .Data_A     (ch[95:84]),
    .Data_B     (ch[83:72]),
    .Data_C     (ch[71:60]),
    .Data_D     (ch[59:48]),
    .Data_E     (ch[47:36]),
    .Data_F     (ch[35:24]),
    .Data_G     (ch[23:12]),
    .Data_H     (ch[11:0]),
    .coff       (coff),
    .cf_en      (cf_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_sol   (dout_sol),
    .dout_idx   (dout_idx)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One valid beat; expected result and arrival cycle go to the scoreboard.
  task automatic beat(input logic [95:0] c, input logic ls, input logic signed [14:0] d);
    ch         = c;
    din_valid  = 1'b1;
    line_start = ls;
    if (ls) model_idx = '0;
    else if (model_idx != {IDX_W{1'b1}}) model_idx = model_idx + 1'b1;
    exp_q.push_back({d, ls, model_idx, cyc + 32'(LAT + 1)});
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    line_start = 1'b0;
  endtask

  // Wait (bounded) for every queued response to come out.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2 * LAT) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  // Monitor: pop and compare on valid output, require idle outputs otherwise.
  initial begin
    logic [59:0] e;
    forever begin
      @(negedge clk);
      if (dout_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: cyc %0d dout %0d sol %0d idx %0d, required no output",
                   cyc, dout, dout_sol, dout_idx);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e[59:45] || dout_sol !== e[44] || dout_idx !== e[43:32] || cyc !== e[31:0]) begin
            fails++;
            $display("FAIL out_beat: got dout %0d sol %0d idx %0d cyc %0d, required dout %0d sol %0d idx %0d cyc %0d",
                     dout, dout_sol, dout_idx, cyc, $signed(e[59:45]), e[44], e[43:32], e[31:0]);
          end
          held_idx = e[43:32];
        end
      end else begin
        tests++;
        if (dout !== 15'sd0 || dout_sol !== 1'b0 || dout_idx !== held_idx) begin
          fails++;
          $display("FAIL idle_out: cyc %0d got dout %0d sol %0d idx %0d, required 0 0 %0d",
                   cyc, dout, dout_sol, dout_idx, held_idx);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    idle(3);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_sol", 32'(dout_sol), 32'd0);
    check("rst_idx", 32'(dout_idx), 32'd0);
    rst = 1'b0;
    idle(2);

    // Full-scale positive, half weight, start of line
    coff = 8'd128; cf_en = 1'b1;
    beat(ALL_FFF, 1'b1, 15'sd8188);
    drain();

    // Full-scale negative, near-unity weight
    coff = 8'd255;
    beat(ALL_000, 1'b0, -15'sd16320);
    drain();

    // Bypass ignores coff; enabled with coff=0 gives zero
    cf_en = 1'b0; coff = 8'd0;
    beat(HALF_C, 1'b0, 15'sd4096);
    drain();
    cf_en = 1'b1;
    beat(HALF_C, 1'b0, 15'sd0);
    drain();

    // Truncation toward minus infinity
    coff = 8'd1;
    beat(A_7FF, 1'b0, -15'sd1);
    beat(A_801, 1'b0, 15'sd0);
    drain();

    // Coefficient alignment: change lands on the multiply edge
    coff = 8'd0;
    beat(ALL_FFF, 1'b0, 15'sd12793);
    idle(LAT - 2);
    coff = 8'd200;
    drain();
    // One edge later the change is too late
    coff = 8'd0;
    beat(ALL_FFF, 1'b0, 15'sd0);
    idle(LAT - 1);
    coff = 8'd200;
    drain();

    // Back-to-back line starts, then a gap that keeps the index
    cf_en = 1'b0; coff = 8'd255;
    beat(A_FFF, 1'b1, 15'sd2047);
    beat(A_FFF, 1'b1, 15'sd2047);
    idle(5);
    beat(A_FFF, 1'b0, 15'sd2047);
    drain();

    // Long line: index runs to saturation, then a new line restarts it
    beat(A_FFF, 1'b1, 15'sd2047);
    for (int i = 0; i < 4999; i++) beat(A_FFF, 1'b0, 15'sd2047);
    beat(A_FFF, 1'b1, 15'sd2047);
    drain();

    // Reset mid-stream with outputs active
    cf_en = 1'b1; coff = 8'd255;
    beat(ALL_000, 1'b1, -15'sd16320);
    for (int i = 0; i < 39; i++) beat(ALL_000, 1'b0, -15'sd16320);
    rst = 1'b1;
    exp_q.delete();
    model_idx = '0;
    held_idx  = '0;
    #1;
    check("async_rst_dout", 32'(dout), 32'd0);
    check("async_rst_valid", 32'(dout_valid), 32'd0);
    check("async_rst_sol", 32'(dout_sol), 32'd0);
    check("async_rst_idx", 32'(dout_idx), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    // First beat after reset without sol: index 1, latency checked by cycle
    beat(ALL_000, 1'b0, -15'sd16320);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
